axi_read_arbiter: RTL and testbench

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/axi_read_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_read_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared state encoding and master indices for the read arbiter
package axi_read_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    localparam int M_ICACHE = 0;
    localparam int M_DCACHE = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: next one-hot grant for two requesters, round-robin or fixed priority to the D-cache
module rr_arbiter2
    import axi_read_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);
    logic w_pick_d;
    always_comb begin
        w_pick_d = !RR_EN || (i_last_grant != 1'(M_DCACHE));
        o_grant  = (i_req != 2'b11) ? i_req : (w_pick_d ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read slave between I-cache (m0) and D-cache (m1), one transaction at a time
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter bit CHECK_LEN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic        m0_rlast,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic        m1_rlast,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        len_err
);
    arb_state_t r_state, w_state_nx;
    logic [1:0] r_grant, w_grant_nx, w_arb_grant;
    logic       r_last_grant, w_last_grant_nx;
    logic [7:0] r_beat_cnt, w_beat_cnt_nx, r_exp_len, w_exp_len_nx;
    logic       r_len_err, w_len_err_nx;
    logic       w_sel, w_addr, w_data, w_ar_hs, w_r_hs;

    rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
        .i_req        ({m1_arvalid, m0_arvalid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant)
    );

    // rst gates the handshakes so they drop in the very cycle reset is raised
    always_comb begin
        w_sel      = r_grant[M_DCACHE];
        w_addr     = (r_state == ADDR) && !rst;
        w_data     = (r_state == DATA) && !rst;
        s_araddr   = w_sel ? m1_araddr : m0_araddr;
        s_arlen    = w_sel ? m1_arlen : m0_arlen;
        s_arsize   = w_sel ? m1_arsize : m0_arsize;
        s_arvalid  = w_addr && (w_sel ? m1_arvalid : m0_arvalid);
        m0_arready = w_addr && r_grant[M_ICACHE] && s_arready;
        m1_arready = w_addr && r_grant[M_DCACHE] && s_arready;
        s_rready   = w_data && (w_sel ? m1_rready : m0_rready);
        m0_rvalid  = w_data && r_grant[M_ICACHE] && s_rvalid;
        m1_rvalid  = w_data && r_grant[M_DCACHE] && s_rvalid;
        m0_rlast   = w_data && r_grant[M_ICACHE] && s_rlast;
        m1_rlast   = w_data && r_grant[M_DCACHE] && s_rlast;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        w_ar_hs    = s_arvalid && s_arready;
        w_r_hs     = s_rvalid && s_rready;
        grant      = r_grant;
        busy       = r_state != IDLE;
        len_err    = r_len_err;
    end

    always_comb begin
        w_state_nx      = r_state;
        w_grant_nx      = r_grant;
        w_last_grant_nx = r_last_grant;
        w_beat_cnt_nx   = r_beat_cnt;
        w_exp_len_nx    = r_exp_len;
        w_len_err_nx    = r_len_err;
        case (r_state)
            IDLE: if (|w_arb_grant) begin
                w_state_nx = ADDR;
                w_grant_nx = w_arb_grant;
            end
            ADDR: if (w_ar_hs) begin
                w_state_nx    = DATA;
                w_beat_cnt_nx = '0;
                w_exp_len_nx  = s_arlen;
            end
            DATA: if (w_r_hs && s_rlast) begin
                w_state_nx      = IDLE;
                w_grant_nx      = '0;
                w_last_grant_nx = w_sel;
                w_len_err_nx    = r_len_err || (CHECK_LEN && (r_beat_cnt != r_exp_len));
            end else if (w_r_hs) begin
                w_beat_cnt_nx = r_beat_cnt + 8'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
            r_exp_len    <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_grant      <= w_grant_nx;
            r_last_grant <= w_last_grant_nx;
            r_beat_cnt   <= w_beat_cnt_nx;
            r_exp_len    <= w_exp_len_nx;
            r_len_err    <= w_len_err_nx;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: random transactions against a transaction-level model of grant order and length errors
module tb_axi_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
    logic [7:0]  m0_arlen, m1_arlen, s_arlen;
    logic [2:0]  m0_arsize, m1_arsize, s_arsize;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [1:0]  grant;
    logic        busy, len_err;

    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
    logic [7:0]  f_s_arlen;
    logic [2:0]  f_s_arsize;
    logic        f_m0_arready, f_m1_arready, f_m0_rlast, f_m1_rlast, f_m0_rvalid, f_m1_rvalid;
    logic        f_s_arvalid, f_s_rready, f_busy, f_len_err;
    logic [1:0]  f_grant;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    // fixed-priority, unchecked-length instance kept permanently saturated with ties and single-beat bursts
    axi_read_arbiter #(.RR_EN(1'b0), .CHECK_LEN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_araddr(32'h1000), .m0_arlen(8'd3), .m0_arsize(3'd2), .m0_arvalid(1'b1),
        .m0_arready(f_m0_arready), .m0_rdata(f_m0_rdata), .m0_rlast(f_m0_rlast), .m0_rvalid(f_m0_rvalid), .m0_rready(1'b1),
        .m1_araddr(32'h2000), .m1_arlen(8'd3), .m1_arsize(3'd2), .m1_arvalid(1'b1),
        .m1_arready(f_m1_arready), .m1_rdata(f_m1_rdata), .m1_rlast(f_m1_rlast), .m1_rvalid(f_m1_rvalid), .m1_rready(1'b1),
        .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize), .s_arvalid(f_s_arvalid), .s_arready(1'b1),
        .s_rdata(32'hCAFE), .s_rlast(1'b1), .s_rvalid(1'b1), .s_rready(f_s_rready),
        .grant(f_grant), .busy(f_busy), .len_err(f_len_err)
    );

    int errs = 0;
    int checks = 0;
    int m_last = 1;
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [1:0] req, input int len, input int nb, input logic [31:0] addr);
        int win, delay, sent, got, bound;
        logic [31:0] aw;
        logic [2:0] sw;
        logic rr_w;
        win = (req == 2'b11) ? ((m_last == 1) ? 0 : 1) : ((req == 2'b10) ? 1 : 0);
        m0_araddr = $urandom; m1_araddr = $urandom;
        m0_arlen = 8'($urandom); m1_arlen = 8'($urandom);
        m0_arsize = 3'($urandom); m1_arsize = 3'($urandom);
        if (win == 1) begin m1_araddr = addr; m1_arlen = 8'(len); end
        else begin m0_araddr = addr; m0_arlen = 8'(len); end
        sw = (win == 1) ? m1_arsize : m0_arsize;
        aw = addr;
        m0_arvalid = req[0];
        m1_arvalid = req[1];
        s_arready = 1'($urandom_range(0, 1));
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_arready", {m1_arready, m0_arready}, 0);
        chk("idle_s_arvalid", s_arvalid, 0);
        step;
        chk("grant", grant, (win == 1) ? 2 : 1);
        delay = $urandom_range(0, 5);
        for (int i = 0; i < delay; i++) begin
            s_arready = 1'b0;
            #1;
            chk("ar_valid_hold", s_arvalid, 1);
            chk("ar_addr_hold", s_araddr, aw);
            chk("ar_len_hold", s_arlen, 8'(len));
            chk("arready_low", {m1_arready, m0_arready}, 0);
            step;
        end
        s_arready = 1'b1;
        #1;
        chk("ar_addr", s_araddr, aw);
        chk("ar_len", s_arlen, 8'(len));
        chk("ar_size", s_arsize, sw);
        chk("arready", {m1_arready, m0_arready}, (win == 1) ? 2 : 1);
        step;
        s_arready = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        sent = 0; got = 0; bound = 0;
        while (sent < nb && bound < 400) begin
            s_rvalid = ($urandom_range(0, 3) != 0);
            s_rlast = s_rvalid ? (sent == nb - 1) : ($urandom_range(0, 5) == 0);
            s_rdata = $urandom;
            m0_rready = ($urandom_range(0, 3) != 0);
            m1_rready = ($urandom_range(0, 3) != 0);
            rr_w = (win == 1) ? m1_rready : m0_rready;
            #1;
            chk("s_rready", s_rready, rr_w);
            chk("rvalid", {m1_rvalid, m0_rvalid}, s_rvalid ? ((win == 1) ? 2 : 1) : 0);
            chk("rlast", {m1_rlast, m0_rlast}, s_rlast ? ((win == 1) ? 2 : 1) : 0);
            chk("rdata0", m0_rdata, s_rdata);
            chk("rdata1", m1_rdata, s_rdata);
            chk("data_busy", busy, 1);
            chk("data_s_arvalid", s_arvalid, 0);
            if (s_rvalid && rr_w) sent++;
            if (((win == 1) ? m1_rvalid : m0_rvalid) && rr_w) got++;
            bound++;
            step;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        if (nb != len + 1) m_err = 1'b1;
        m_last = win;
        #1;
        chk("bound", bound < 400, 1);
        chk("beats", got, nb);
        chk("done_busy", busy, 0);
        chk("done_grant", grant, 0);
        chk("len_err", len_err, m_err);
    endtask

    initial begin
        int len, nb, fp_seen;
        m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0; m0_arsize = '0; m1_arsize = '0;
        m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
        s_arready = 0; s_rdata = '0; s_rlast = 0; s_rvalid = 0;
        repeat (3) step;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
        rst = 0;
        step;
        run_txn(2'b11, 3, 4, 32'h0000_1000);
        run_txn(2'b11, 2, 3, 32'h0000_2000);
        run_txn(2'b01, 15, 16, 32'h1FC0_0000);
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(0, 7);
            nb = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(1, len) : len + 1;
            run_txn(2'($urandom_range(1, 3)), len, nb, $urandom);
        end
        run_txn(2'b01, 15, 8, 32'h0000_3000);
        run_txn(2'b10, 4, 5, 32'h0000_4000);
        m0_araddr = 32'h1FC0_0000; m0_arlen = 8'd15; m0_arvalid = 1; s_arready = 1;
        step;
        chk("rb_araddr", s_araddr, 32'h1FC0_0000);
        step;
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; m0_rready = 1; s_rlast = 0;
        repeat (3) step;
        rst = 1;
        #1;
        chk("rb_same_cycle", {s_rready, m0_rvalid, m1_rvalid}, 0);
        step;
        s_rvalid = 0;
        #1;
        chk("rb_grant", grant, 0);
        chk("rb_busy", busy, 0);
        chk("rb_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
        chk("rb_len_err", len_err, 0);
        rst = 0;
        m_last = 1; m_err = 1'b0;
        run_txn(2'b10, 6, 7, 32'h0000_5000);
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 7);
            run_txn(2'($urandom_range(1, 3)), len, len + 1, $urandom);
        end
        fp_seen = 0;
        for (int i = 0; i < 24; i++) begin
            step;
            if (f_busy) begin
                chk("fp_grant", f_grant, 2'b10);
                fp_seen++;
            end
            chk("fp_len_err", f_len_err, 0);
        end
        chk("fp_active", fp_seen > 0, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
